// File: rtl/seq_pattern_detector_if.sv
// Serial pattern-detector bus: stimulus/control from the master, match status back from the slave.
interface seq_pattern_detector_if #(
  parameter int N     = 9,
  parameter int CNT_W = 8
);
  logic             x;
  logic             en;
  logic             overlap;
  logic             load;
  logic [N-1:0]     pat_in;
  logic             clr_cnt;
  logic             Z;
  logic             primed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x, en, overlap, load, pat_in, clr_cnt,
    input  Z, primed, match_cnt
  );

  modport slave (
    input  x, en, overlap, load, pat_in, clr_cnt,
    output Z, primed, match_cnt
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial N-bit pattern detector with loadable pattern, optional overlapping matches
// and a saturating match counter.
module seq_pattern_detector #(
  parameter int             N       = 9,
  parameter logic [N-1:0]   RST_PAT = 9'b100100100,
  parameter int             CNT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  seq_pattern_detector_if.slave bus
);

  localparam int                FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  logic [N-1:0]      pat;
  logic [N-1:0]      hist;
  logic [N-1:0]      hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              match;
  logic              z_p0;
  logic [CNT_W-1:0]  cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Match is judged on the post-shift history so Z fires one edge after the last bit.
  always_comb begin
    hist_nxt = {hist[N-2:0], bus.x};
    fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    match    = bus.en && !bus.load && (fill_nxt == FILL_FULL) && (hist_nxt == pat);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pat  <= RST_PAT;
      hist <= '0;
      fill <= '0;
    end else if (bus.load) begin
      pat  <= bus.pat_in;
      hist <= '0;
      fill <= '0;
    end else if (bus.en) begin
      hist <= hist_nxt;
      fill <= (match && !bus.overlap) ? '0 : fill_nxt;
    end
  end

  // ---- output stage p0: match pulse and counter (clear wins over increment)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      z_p0   <= 1'b0;
      cnt_p0 <= '0;
    end else begin
      z_p0 <= match;
      if (bus.clr_cnt)
        cnt_p0 <= '0;
      else if (match)
        cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign bus.Z         = z_p0;
  assign bus.primed    = (fill == FILL_FULL);
  assign bus.match_cnt = cnt_p0;

endmodule
